// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read handshake plus the decoder-side
// control inputs and instruction/PC outputs.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_readdata;
    logic              imem_busywait;

    logic              stall;
    logic              jump;
    logic              branch_taken;
    logic [7:0]        offset;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;

    modport master (
        output imem_read, imem_address, instruction, instr_valid, pc,
        input  imem_readdata, imem_busywait, stall, jump, branch_taken, offset
    );

    modport slave (
        input  imem_read, imem_address, instruction, instr_valid, pc,
        output imem_readdata, imem_busywait, stall, jump, branch_taken, offset
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, reads one word per instruction from
// instruction memory and presents it to the decoder until it retires.
//
// state | meaning
// FETCH | read request issued for the word at PC
// WAIT  | waiting for busywait to drop, then latch the word
// EXEC  | instruction valid; advance PC when not stalled
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] offset_bytes;
    logic [31:0]       instr_q;
    logic              read_q;
    logic              latch;
    logic              advance;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        advance   = 1'b0;
        case (state)
            FETCH: state_nxt = WAIT;
            WAIT: begin
                if (!bus.imem_busywait) begin
                    latch     = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!bus.stall) begin
                    advance   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Word offset to bytes; jump and taken branch share one adder path.
    assign offset_bytes = {{(ADDR_W-10){bus.offset[7]}}, bus.offset, 2'b00};

    always_comb begin
        pc_nxt = pc_q + ADDR_W'(PC_STEP);
        if (bus.jump || bus.branch_taken) begin
            pc_nxt = pc_q + ADDR_W'(PC_STEP) + offset_bytes;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            read_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Registered so the request only rises on the first edge after reset.
            read_q <= (state_nxt != EXEC);
            if (latch) begin
                instr_q <= bus.imem_readdata;
            end
            if (advance) begin
                pc_q <= pc_nxt;
            end
        end
    end

    assign bus.imem_read    = read_q;
    assign bus.imem_address = pc_q;
    assign bus.pc           = pc_q;
    assign bus.instruction  = instr_q;
    assign bus.instr_valid  = (state == EXEC);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: bench-side memory, transaction-level PC
// model, directed scenarios followed by randomized instruction sequences.
module tb_instruction_fetch_unit;

    logic clk;
    logic rst;
    logic busy;

    int total;
    int bad;

    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    bit          after_reset;

    instruction_fetch_unit_if #(.ADDR_W(32)) bus ();

    instruction_fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(32'd0),
        .PC_STEP (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0102_0304 ^ (a * 32'h9E37_79B1);
    endfunction

    assign bus.imem_busywait = busy;
    assign bus.imem_readdata = busy ? 32'hDEAD_BEEF : mem_word(bus.imem_address);

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input bit j,
                                            input bit b, input logic [7:0] off);
        int delta;
        delta = (j || b) ? int'($signed(off)) * 4 : 0;
        return pc + 32'd4 + 32'(delta);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ctrl();
        bus.jump         = 1'($urandom_range(0, 1));
        bus.branch_taken = 1'($urandom_range(0, 1));
        bus.offset       = 8'($urandom);
    endtask

    // Called at edge+1; asserts reset asynchronously, checks, releases at next edge+1.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pc",    bus.pc, 32'd0);
        chk("rst_addr",  bus.imem_address, 32'd0);
        chk("rst_read",  32'(bus.imem_read), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instruction, 32'd0);
        tick();
        rst         = 1'b0;
        exp_pc      = 32'd0;
        exp_instr   = 32'd0;
        after_reset = 1'b1;
    endtask

    // One instruction from FETCH to the advance edge.
    task automatic run_instr(input int nbusy, input int nstall, input bit j,
                             input bit b, input logic [7:0] off);
        if (!after_reset) chk("fetch_read", 32'(bus.imem_read), 32'd1);
        chk("fetch_valid", 32'(bus.instr_valid), 32'd0);
        chk("fetch_pc",    bus.pc, exp_pc);
        chk("fetch_addr",  bus.imem_address, exp_pc);
        after_reset = 1'b0;
        bus.stall = 1'($urandom_range(0, 1));
        scramble_ctrl();
        busy = 1'($urandom_range(0, 1));
        tick();
        for (int k = 0; k <= nbusy; k++) begin
            chk("wait_read",  32'(bus.imem_read), 32'd1);
            chk("wait_addr",  bus.imem_address, exp_pc);
            chk("wait_valid", 32'(bus.instr_valid), 32'd0);
            chk("wait_hold",  bus.instruction, exp_instr);
            busy      = (k < nbusy);
            bus.stall = 1'($urandom_range(0, 1));
            scramble_ctrl();
            tick();
        end
        exp_instr = mem_word(exp_pc);
        chk("exec_valid", 32'(bus.instr_valid), 32'd1);
        chk("exec_instr", bus.instruction, exp_instr);
        chk("exec_read",  32'(bus.imem_read), 32'd0);
        chk("exec_pc",    bus.pc, exp_pc);
        busy = 1'($urandom_range(0, 1));
        for (int s = 0; s < nstall; s++) begin
            bus.stall = 1'b1;
            scramble_ctrl();
            tick();
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_instr", bus.instruction, exp_instr);
            chk("stall_pc",    bus.pc, exp_pc);
        end
        bus.stall        = 1'b0;
        bus.jump         = j;
        bus.branch_taken = b;
        bus.offset       = off;
        tick();
        exp_pc = next_pc(exp_pc, j, b, off);
        chk("adv_valid", 32'(bus.instr_valid), 32'd0);
        chk("adv_pc",    bus.pc, exp_pc);
        chk("adv_addr",  bus.imem_address, exp_pc);
        chk("adv_read",  32'(bus.imem_read), 32'd1);
        chk("adv_instr", bus.instruction, exp_instr);
        busy = 1'b0;
        scramble_ctrl();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        busy             = 1'b0;
        bus.stall        = 1'b0;
        bus.jump         = 1'b0;
        bus.branch_taken = 1'b0;
        bus.offset       = 8'h00;
        exp_pc           = 32'd0;
        exp_instr        = 32'd0;
        after_reset      = 1'b1;
        #3;
        chk("por_pc",    bus.pc, 32'd0);
        chk("por_read",  32'(bus.imem_read), 32'd0);
        chk("por_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        do_reset();

        // Busywait on the very first fetch: valid appears on the 5th edge.
        run_instr(3, 0, 1'b0, 1'b0, 8'h00);
        chk("busy_first_pc", bus.pc, 32'd4);

        tick();
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 8'h00);
        chk("seq_pc4", bus.pc, 32'd4);
        run_instr(0, 0, 1'b0, 1'b0, 8'h11);
        chk("seq_pc8", bus.pc, 32'd8);
        run_instr(0, 0, 1'b1, 1'b0, 8'hFE);
        chk("jump_back", bus.pc, 32'd4);
        run_instr(1, 0, 1'b0, 1'b1, 8'h03);
        chk("branch_fwd", bus.pc, 32'd20);
        run_instr(0, 4, 1'b0, 1'b0, 8'h55);
        chk("not_taken", bus.pc, 32'd24);
        run_instr(2, 1, 1'b1, 1'b1, 8'h7F);
        chk("both_max", bus.pc, 32'd24 + 32'd4 + 32'd508);
        run_instr(0, 0, 1'b0, 1'b1, 8'h80);
        chk("branch_min", bus.pc, 32'd536 + 32'd4 - 32'd512);

        // Reach PC=12, then reset in the middle of WAIT.
        tick();
        do_reset();
        run_instr(0, 0, 1'b0, 1'b0, 8'h00);
        run_instr(0, 0, 1'b0, 1'b0, 8'h00);
        run_instr(0, 0, 1'b0, 1'b0, 8'h00);
        busy = 1'b1;
        tick();
        tick();
        chk("midwait_addr", bus.imem_address, 32'd12);
        chk("midwait_read", 32'(bus.imem_read), 32'd1);
        #2;
        do_reset();
        busy = 1'b1;
        run_instr(0, 0, 1'b0, 1'b0, 8'h00);
        chk("restart_pc", bus.pc, 32'd4);

        // Wrap-around: jump from 0 by -2 words lands on 0xFFFFFFFC.
        tick();
        do_reset();
        run_instr(0, 0, 1'b1, 1'b0, 8'hFE);
        chk("wrap_top", bus.pc, 32'hFFFF_FFFC);
        run_instr(1, 0, 1'b0, 1'b0, 8'h00);
        chk("wrap_zero", bus.pc, 32'd0);

        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
